// File: rtl/bl_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : bl_mux_arb
//  Purpose  : Registered N_CH-to-1 address-bus multiplexer with round-robin
//             arbitration. Each upstream channel has a one-entry holding
//             register. One buffered request per cycle is forwarded to a
//             single downstream port, tagged with its source channel.
//             Both sides use a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W   address width per channel
//    N_CH     number of upstream channels (2..16)
//    CH_W     derived channel-index width, $clog2(N_CH)
//  Ports
//    CLK      in   1              rising-edge clock
//    Reset    in   1              asynchronous active-low reset
//    EN_in    in   N_CH           per-channel request valid
//    A_in     in   N_CH*ADDR_W    per-channel address, ch i at [i*ADDR_W +: ADDR_W]
//    Rdy_in   out  N_CH           per-channel accept (holding register empty)
//    A_out    out  ADDR_W         forwarded address
//    Ch_out   out  CH_W           source channel of A_out
//    EN_out   out  1              downstream valid
//    Rdy_out  in   1              downstream ready
// ============================================================================
module bl_mux_arb #(
  parameter int ADDR_W = 3,
  parameter int N_CH   = 2,
  localparam int CH_W  = $clog2(N_CH)
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [N_CH-1:0]          EN_in,
  input  logic [N_CH*ADDR_W-1:0]   A_in,
  output logic [N_CH-1:0]          Rdy_in,
  output logic [ADDR_W-1:0]        A_out,
  output logic [CH_W-1:0]          Ch_out,
  output logic                     EN_out,
  input  logic                     Rdy_out
);

  // Channel count and last channel index at the widths used by the
  // pointer arithmetic. The extended width leaves room for ptr + offset
  // before the wrap, so non-power-of-two N_CH works.
  localparam logic [CH_W:0]   N_CH_EXT = (CH_W+1)'(N_CH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(N_CH - 1);

  // --------------------------------------------------------------------------
  // Per-channel state
  // --------------------------------------------------------------------------
  logic [N_CH-1:0]             pend;
  logic [N_CH-1:0][ADDR_W-1:0] hold;
  logic [N_CH-1:0]             capture;
  logic [N_CH-1:0]             grant_oh;

  // --------------------------------------------------------------------------
  // Arbitration and output-register control
  // --------------------------------------------------------------------------
  logic            load;
  logic            take;
  logic            grant_vld;
  logic [CH_W-1:0] grant;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] ptr_nxt;
  logic [CH_W:0]   cand;

  // The output register may accept a new entry when it is empty, or when
  // its current entry is being consumed on this edge.
  assign load = ~EN_out | Rdy_out;
  assign take = load & grant_vld;

  // Round-robin search starting at ptr. The loop runs from the farthest
  // offset down to offset 0. A later match overrides an earlier one, so the
  // pending channel closest to ptr (in wrap order) wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (CH_W+1)'(k);
      if (cand >= N_CH_EXT) begin
        cand = cand - N_CH_EXT;
      end
      if (pend[cand[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = cand[CH_W-1:0];
      end
    end
  end

  // The pointer moves past the granted channel. The wrap is explicit
  // because N_CH need not be a power of two.
  always_comb begin
    ptr_nxt = '0;
    if (grant != LAST_CH) begin
      ptr_nxt = grant + CH_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel holding registers
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              pend_q;
    logic [ADDR_W-1:0] hold_q;

    // Accept depends only on registered state and reset. It has no path
    // from EN_in or Rdy_out.
    assign Rdy_in[i]   = Reset & ~pend_q;
    assign capture[i]  = EN_in[i] & Rdy_in[i];
    assign grant_oh[i] = take & (grant == CH_W'(i));

    // Capture needs an empty slot and a grant needs a full one, so the
    // two can never hit the same channel on the same edge.
    always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
        pend_q <= 1'b0;
        hold_q <= '0;
      end else if (capture[i]) begin
        pend_q <= 1'b1;
        hold_q <= A_in[i*ADDR_W +: ADDR_W];
      end else if (grant_oh[i]) begin
        pend_q <= 1'b0;
      end
    end

    assign pend[i] = pend_q;
    assign hold[i] = hold_q;
  end : g_ch

  // --------------------------------------------------------------------------
  // Output register and round-robin pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      EN_out <= 1'b0;
      A_out  <= '0;
      Ch_out <= '0;
      ptr    <= '0;
    end else if (load) begin
      if (grant_vld) begin
        A_out  <= hold[grant];
        Ch_out <= grant;
        EN_out <= 1'b1;
        ptr    <= ptr_nxt;
      end else begin
        // Nothing to forward: drop valid but keep the last address/tag.
        EN_out <= 1'b0;
      end
    end
  end

endmodule : bl_mux_arb
`default_nettype wire

// File: tb/tb_bl_mux_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bl_mux_arb
//  Purpose  : Self-checking bench for bl_mux_arb with three channels, so the
//             round-robin wrap is not a power of two. The bench keeps a
//             behavioural reference model: request slots, a pointer and an
//             output slot, advanced once per rising edge. After every edge
//             the model is compared with all DUT outputs. Directed sequences
//             add fixed expected values on top of the model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bl_mux_arb;

  localparam int W = 3;
  localparam int N = 3;
  localparam int CW = $clog2(N);

  logic              CLK;
  logic              Reset;
  logic [N-1:0]      EN_in;
  logic [N*W-1:0]    A_in;
  logic [N-1:0]      Rdy_in;
  logic [W-1:0]      A_out;
  logic [CW-1:0]     Ch_out;
  logic              EN_out;
  logic              Rdy_out;

  bl_mux_arb #(.ADDR_W(W), .N_CH(N)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .EN_in   (EN_in),
    .A_in    (A_in),
    .Rdy_in  (Rdy_in),
    .A_out   (A_out),
    .Ch_out  (Ch_out),
    .EN_out  (EN_out),
    .Rdy_out (Rdy_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  bit m_pend [N];
  int m_hold [N];
  int m_ptr;
  bit m_en;
  int m_a;
  int m_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_hold[i] = 0;
    end
    m_ptr = 0;
    m_en  = 1'b0;
    m_a   = 0;
    m_ch  = 0;
  endtask

  // One rising edge of the specified behaviour
  task automatic model_step();
    bit cap [N];
    bit ld;
    int g;
    ld = !m_en || Rdy_out;
    g  = -1;
    for (int i = 0; i < N; i++) cap[i] = EN_in[i] && !m_pend[i];
    if (ld) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && m_pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      if (g >= 0) begin
        m_a       = m_hold[g];
        m_ch      = g;
        m_en      = 1'b1;
        m_pend[g] = 1'b0;
        m_ptr     = (g + 1) % N;
      end else begin
        m_en = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cap[i]) begin
        m_pend[i] = 1'b1;
        m_hold[i] = int'(A_in[i*W +: W]);
      end
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = Reset && !m_pend[i];
    check("en_out", 32'(EN_out), 32'(m_en));
    check("a_out",  32'(A_out),  32'(m_a));
    check("ch_out", 32'(Ch_out), 32'(m_ch));
    check("rdy_in", 32'(Rdy_in), 32'(r));
  endtask

  // Advance one rising edge and check on the following falling edge.
  task automatic tick();
    @(posedge CLK);
    if (Reset) model_step();
    @(negedge CLK);
    compare_all();
  endtask

  task automatic drain();
    EN_in   = '0;
    Rdy_out = 1'b1;
    repeat (4) tick();
  endtask

  int prev_ch;

  initial begin
    model_reset();
    Reset   = 1'b0;
    EN_in   = '1;
    A_in    = '1;
    Rdy_out = 1'b1;

    // ---- Reset with all channels requesting
    #1;
    check("rst_en_out", 32'(EN_out), 32'd0);
    check("rst_rdy_in", 32'(Rdy_in), 32'd0);
    repeat (2) tick();
    check("rst_a_out", 32'(A_out), 32'd0);
    check("rst_ch_out", 32'(Ch_out), 32'd0);
    Reset = 1'b1;
    #1;
    check("rst_rel_rdy", 32'(Rdy_in), 32'h7);
    EN_in = '0;
    tick();
    check("rst_nocap", 32'(Rdy_in), 32'h7);

    // ---- Single request on ch0
    EN_in = 3'b001;
    A_in[0 +: W] = 3'b101;
    tick();
    check("single_rdy0_busy", 32'(Rdy_in[0]), 32'd0);
    EN_in = '0;
    tick();
    check("single_en", 32'(EN_out), 32'd1);
    check("single_a", 32'(A_out), 32'h5);
    check("single_ch", 32'(Ch_out), 32'd0);
    check("single_rdy0_free", 32'(Rdy_in[0]), 32'd1);
    tick();
    check("single_idle", 32'(EN_out), 32'd0);

    // ---- ch2 alone: grant wraps the pointer from 2 back to 0
    EN_in = 3'b100;
    A_in[2*W +: W] = 3'b011;
    tick();
    EN_in = '0;
    tick();
    check("wrap_ch", 32'(Ch_out), 32'd2);
    tick();

    // ---- Simultaneous capture on ch0 and ch1 with the pointer at 0
    EN_in = 3'b011;
    A_in[0 +: W] = 3'b101;
    A_in[W +: W] = 3'b010;
    tick();
    EN_in = '0;
    tick();
    check("simul_ch_a", 32'(Ch_out), 32'd0);
    check("simul_a_a", 32'(A_out), 32'h5);
    tick();
    check("simul_ch_b", 32'(Ch_out), 32'd1);
    check("simul_a_b", 32'(A_out), 32'h2);
    tick();
    check("simul_idle", 32'(EN_out), 32'd0);

    // ---- Round-robin: ch0 and ch1 re-request whenever they are accepted
    prev_ch = -1;
    for (int c = 0; c < 10; c++) begin
      EN_in = {1'b0, Rdy_in[1:0]};
      A_in  = N*W'($urandom);
      tick();
      if (EN_out) begin
        if (prev_ch >= 0) check("rr_alternate", 32'(Ch_out != CW'(prev_ch)), 32'd1);
        prev_ch = int'(Ch_out);
      end
    end
    drain();

    // ---- Backpressure: ch1 in the output register, ch0 pending
    EN_in = 3'b010;
    A_in[W +: W] = 3'b010;
    tick();
    EN_in = 3'b001;
    A_in[0 +: W] = 3'b101;
    tick();
    EN_in   = '0;
    Rdy_out = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_en", 32'(EN_out), 32'd1);
      check("bp_ch", 32'(Ch_out), 32'd1);
      check("bp_a", 32'(A_out), 32'h2);
      check("bp_rdy0", 32'(Rdy_in[0]), 32'd0);
    end
    Rdy_out = 1'b1;
    tick();
    check("bp_next_ch", 32'(Ch_out), 32'd0);
    check("bp_next_a", 32'(A_out), 32'h5);
    drain();

    // ---- Reset in the middle of traffic
    EN_in = 3'b100;
    A_in[2*W +: W] = 3'b110;
    tick();
    EN_in = 3'b011;
    tick();
    EN_in   = '0;
    Rdy_out = 1'b0;
    tick();
    check("mid_pre_en", 32'(EN_out), 32'd1);
    check("mid_pre_rdy", 32'(Rdy_in), 32'h4);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check("mid_async_en", 32'(EN_out), 32'd0);
    check("mid_async_a", 32'(A_out), 32'd0);
    check("mid_async_ch", 32'(Ch_out), 32'd0);
    check("mid_async_rdy", 32'(Rdy_in), 32'd0);
    tick();
    Reset   = 1'b1;
    Rdy_out = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("mid_no_stale", 32'(EN_out), 32'd0);
    end

    // ---- Randomised traffic with backpressure and occasional resets
    for (int c = 0; c < 400; c++) begin
      Reset   = 1'b1;
      EN_in   = N'($urandom);
      A_in    = N*W'($urandom);
      Rdy_out = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) begin
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        compare_all();
      end
      tick();
    end
    Reset = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_bl_mux_arb
`default_nettype wire
